// File: rtl/taxi_eth_10g_pkg.sv
// Shared 10GBASE-R constants: sync headers, control block type, idle block
// and the gearbox sequencer state encoding.
package taxi_eth_10g_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BLOCK_TYPE_CTRL = 8'h1E;

  // All-control block carrying eight idle characters (7'h00 each).
  localparam logic [63:0] IDLE_BLOCK = {56'd0, BLOCK_TYPE_CTRL};

  typedef logic [0:0] gbx_state_t;

  localparam gbx_state_t ALIGN = 1'b0;
  localparam gbx_state_t RUN   = 1'b1;

endpackage

// File: rtl/taxi_eth_phy_10g_tx_gbx_seq.sv
// Paces encoded 64b/66b blocks into the 10G PHY TX interface for an async
// gearbox, inserting idle blocks whenever the encoder has nothing in a slot.
module taxi_eth_phy_10g_tx_gbx_seq
  import taxi_eth_10g_pkg::*;
#(
  parameter int   DATA_W  = 64,
  parameter int   HDR_W   = 2,
  parameter logic GBX_EN  = 1'b1,
  parameter int   GBX_CNT = 33
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [DATA_W-1:0] s_data,
  input  logic [HDR_W-1:0]  s_hdr,
  input  logic              s_valid,
  output logic              s_ready,

  output logic [DATA_W-1:0] encoded_tx_data,
  output logic              encoded_tx_data_valid,
  output logic [HDR_W-1:0]  encoded_tx_hdr,
  output logic              encoded_tx_hdr_valid,
  output logic              tx_gbx_start,
  input  logic              tx_gbx_req_start,
  input  logic              tx_gbx_req_stall,

  input  logic              cfg_gbx_ext,

  output logic              stat_tx_idle_ins,
  output logic              stat_tx_aligned
);

  localparam int CNT_W = (GBX_CNT > 1) ? $clog2(GBX_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GBX_CNT - 1);

  if (DATA_W != 64) begin : g_bad_data_w
    $fatal(1, "DATA_W must be 64");
  end
  if (HDR_W != 2) begin : g_bad_hdr_w
    $fatal(1, "HDR_W must be 2");
  end
  if (GBX_CNT < 2) begin : g_bad_gbx_cnt
    $fatal(1, "GBX_CNT must be at least 2");
  end

  gbx_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             start_pend_reg, start_pend_next;
  logic             cfg_ext_reg;

  logic stall;
  logic slot;
  logic start_req;
  logic cfg_chg;

  // Slot qualification deliberately ignores s_valid so the encoder sees a
  // ready that does not depend on its own valid.
  assign stall   = GBX_EN && (cfg_gbx_ext ? tx_gbx_req_stall : (cnt_reg == CNT_LAST));
  assign slot    = (state_reg == RUN) && !stall;
  assign s_ready = slot;

  assign cfg_chg   = GBX_EN && (cfg_gbx_ext != cfg_ext_reg);
  assign start_req = GBX_EN && (start_pend_reg ||
                     ((state_reg == RUN) && cfg_gbx_ext && tx_gbx_req_start));

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    start_pend_next = start_pend_reg;

    if (state_reg == ALIGN) begin
      cnt_next = '0;
      if (!GBX_EN || !cfg_gbx_ext || tx_gbx_req_start) begin
        state_next      = RUN;
        start_pend_next = GBX_EN;
      end
    end else begin
      cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
      // A pending start survives stalled cycles and is consumed by a slot.
      start_pend_next = slot ? 1'b0 : start_req;
    end

    // A mode switch restarts alignment; the word accepted this cycle still goes out.
    if (cfg_chg) begin
      state_next      = ALIGN;
      cnt_next        = '0;
      start_pend_next = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg             <= GBX_EN ? ALIGN : RUN;
      cnt_reg               <= '0;
      start_pend_reg        <= 1'b0;
      cfg_ext_reg           <= cfg_gbx_ext;
      encoded_tx_data       <= '0;
      encoded_tx_hdr        <= '0;
      encoded_tx_data_valid <= 1'b0;
      tx_gbx_start          <= 1'b0;
      stat_tx_idle_ins      <= 1'b0;
      stat_tx_aligned       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      start_pend_reg <= start_pend_next;
      cfg_ext_reg    <= cfg_gbx_ext;

      encoded_tx_data_valid <= slot;
      tx_gbx_start          <= slot && start_req;
      stat_tx_idle_ins      <= slot && !s_valid;
      stat_tx_aligned       <= (state_next == RUN);

      if (slot) begin
        encoded_tx_data <= s_valid ? s_data : IDLE_BLOCK;
        encoded_tx_hdr  <= s_valid ? s_hdr  : SYNC_CTRL;
      end
    end
  end

  assign encoded_tx_hdr_valid = encoded_tx_data_valid;

endmodule

// File: tb/tb_taxi_eth_phy_10g_tx_gbx_seq.sv
// Directed bench for the 10G TX gearbox sequencer: a slot-level behavioural
// model checks both a paced instance and an unpaced (GBX_EN = 0) instance.
module tb_taxi_eth_phy_10g_tx_gbx_seq;

  localparam int GBX_CNT = 33;
  localparam logic [63:0] IDLE_WORD = 64'h000000000000001E;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_data = 64'h0123_4567_0000_0000;
  logic [1:0]  s_hdr = 2'b01;
  logic        s_valid = 1'b1;
  logic        req_start = 1'b0;
  logic        req_stall = 1'b0;
  logic        cfg_ext = 1'b0;

  logic        s_ready, tx_data_valid, tx_hdr_valid, tx_start, idle_ins, aligned;
  logic [63:0] tx_data;
  logic [1:0]  tx_hdr;

  logic        u1_ready, u1_data_valid, u1_hdr_valid, u1_start, u1_idle_ins, u1_aligned;
  logic [63:0] u1_data;
  logic [1:0]  u1_hdr;

  always #5 clk = ~clk;

  taxi_eth_phy_10g_tx_gbx_seq #(
    .DATA_W(64), .HDR_W(2), .GBX_EN(1'b1), .GBX_CNT(GBX_CNT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_hdr(s_hdr), .s_valid(s_valid), .s_ready(s_ready),
    .encoded_tx_data(tx_data), .encoded_tx_data_valid(tx_data_valid),
    .encoded_tx_hdr(tx_hdr), .encoded_tx_hdr_valid(tx_hdr_valid),
    .tx_gbx_start(tx_start),
    .tx_gbx_req_start(req_start), .tx_gbx_req_stall(req_stall),
    .cfg_gbx_ext(cfg_ext),
    .stat_tx_idle_ins(idle_ins), .stat_tx_aligned(aligned)
  );

  taxi_eth_phy_10g_tx_gbx_seq #(
    .DATA_W(64), .HDR_W(2), .GBX_EN(1'b0), .GBX_CNT(GBX_CNT)
  ) dut_nogbx (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_hdr(s_hdr), .s_valid(s_valid), .s_ready(u1_ready),
    .encoded_tx_data(u1_data), .encoded_tx_data_valid(u1_data_valid),
    .encoded_tx_hdr(u1_hdr), .encoded_tx_hdr_valid(u1_hdr_valid),
    .tx_gbx_start(u1_start),
    .tx_gbx_req_start(req_start), .tx_gbx_req_stall(req_stall),
    .cfg_gbx_ext(cfg_ext),
    .stat_tx_idle_ins(u1_idle_ins), .stat_tx_aligned(u1_aligned)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: "running" plus cycles-since-running decides the stall slot by
  // modular arithmetic; a pending-start flag tracks the next sequence start.
  bit          m_run = 1'b0;
  int          m_phase = 0;
  bit          m_pend = 1'b0;
  bit          m_cfg = 1'b0;
  logic [63:0] e_data = '0;
  logic [1:0]  e_hdr = '0;
  logic        e_valid = 1'b0, e_start = 1'b0, e_idle = 1'b0, e_aligned = 1'b0;
  logic [63:0] e1_data = '0;
  logic [1:0]  e1_hdr = '0;
  logic        e1_valid = 1'b0, e1_idle = 1'b0, e1_aligned = 1'b0;

  logic ob_ready, ob_valid, ob_start, ob_idle;
  int   u1_start_cnt = 0;

  task automatic model_step();
    bit stall, slot, want;
    stall = cfg_ext ? req_stall : ((m_phase % GBX_CNT) == GBX_CNT - 1);
    slot  = m_run && !stall;

    check("ready",      {63'd0, s_ready},       {63'd0, slot});
    check("data",       tx_data,                e_data);
    check("hdr",        {62'd0, tx_hdr},        {62'd0, e_hdr});
    check("data_valid", {63'd0, tx_data_valid}, {63'd0, e_valid});
    check("hdr_valid",  {63'd0, tx_hdr_valid},  {63'd0, e_valid});
    check("gbx_start",  {63'd0, tx_start},      {63'd0, e_start});
    check("idle_ins",   {63'd0, idle_ins},      {63'd0, e_idle});
    check("aligned",    {63'd0, aligned},       {63'd0, e_aligned});
    check("nogbx_ready",     {63'd0, u1_ready},      64'd1);
    check("nogbx_data",      u1_data,                e1_data);
    check("nogbx_hdr",       {62'd0, u1_hdr},        {62'd0, e1_hdr});
    check("nogbx_valid",     {63'd0, u1_data_valid}, {63'd0, e1_valid});
    check("nogbx_hdr_valid", {63'd0, u1_hdr_valid},  {63'd0, e1_valid});
    check("nogbx_start",     {63'd0, u1_start},      64'd0);
    check("nogbx_idle",      {63'd0, u1_idle_ins},   {63'd0, e1_idle});
    check("nogbx_aligned",   {63'd0, u1_aligned},    {63'd0, e1_aligned});

    if (rst) begin
      m_run = 1'b0; m_phase = 0; m_pend = 1'b0; m_cfg = cfg_ext;
      e_data = '0; e_hdr = '0; e_valid = 1'b0; e_start = 1'b0; e_idle = 1'b0; e_aligned = 1'b0;
      e1_data = '0; e1_hdr = '0; e1_valid = 1'b0; e1_idle = 1'b0; e1_aligned = 1'b0;
    end else begin
      want    = m_pend || (m_run && cfg_ext && req_start);
      e_valid = slot;
      e_start = slot && want;
      e_idle  = slot && !s_valid;
      if (slot) begin
        e_data = s_valid ? s_data : IDLE_WORD;
        e_hdr  = s_valid ? s_hdr : 2'b10;
      end
      if (!m_run) begin
        if (!cfg_ext || req_start) begin
          m_run = 1'b1; m_phase = 0; m_pend = 1'b1;
        end
      end else begin
        m_phase++;
        m_pend = slot ? 1'b0 : want;
      end
      if (cfg_ext != m_cfg) begin
        m_run = 1'b0; m_pend = 1'b0;
      end
      m_cfg     = cfg_ext;
      e_aligned = m_run;

      e1_valid   = 1'b1;
      e1_data    = s_valid ? s_data : IDLE_WORD;
      e1_hdr     = s_valid ? s_hdr : 2'b10;
      e1_idle    = !s_valid;
      e1_aligned = 1'b1;
    end
  endtask

  // One clock: check and predict away from the edge, then advance the source.
  task automatic tick();
    bit xfer;
    @(negedge clk);
    ob_ready = s_ready; ob_valid = tx_data_valid; ob_start = tx_start; ob_idle = idle_ins;
    if (u1_start) u1_start_cnt++;
    xfer = s_valid && s_ready;
    model_step();
    @(posedge clk);
    #1;
    if (xfer) s_data = s_data + 64'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, bad, slots, idle_seen;

    // Internal mode start-up.
    repeat (3) tick();
    rst = 1'b0;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ob_start && first < 0) first = k;
    end
    check("first_start_cycle", 64'(first), 64'd2);

    repeat (40) tick();
    bad = 0;
    for (int k = 0; k < 2 * GBX_CNT; k++) begin
      tick();
      if (!ob_valid) bad++;
    end
    check("stalls_per_66", 64'(bad), 64'd2);

    // Encoder underflow for three slots.
    slots = 0; idle_seen = 0;
    for (int k = 0; k < 12; k++) begin
      s_valid = (slots < 3) ? 1'b0 : 1'b1;
      tick();
      if (ob_idle) idle_seen++;
      if (ob_ready && !s_valid) slots++;
    end
    s_valid = 1'b1;
    check("idle_inserted", 64'(idle_seen), 64'd3);

    // Switch to external mode: realign and wait for a start request.
    cfg_ext = 1'b1;
    tick();
    tick();
    check("ready_after_mode_switch", {63'd0, ob_ready}, 64'd0);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (ob_ready || ob_valid) bad++;
    end
    check("ext_align_quiet", 64'(bad), 64'd0);

    req_start = 1'b1;
    tick();
    req_start = 1'b0;
    first = -1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ob_valid && first < 0) begin
        first = k;
        check("ext_first_word_start", {63'd0, ob_start}, 64'd1);
      end
    end
    check("ext_first_word_cycle", 64'(first), 64'd1);

    // External stalls, alone and together with a start request.
    repeat (10) tick();
    req_stall = 1'b1;
    tick();
    req_stall = 1'b0;
    repeat (3) tick();
    req_start = 1'b1; req_stall = 1'b1;
    tick();
    req_start = 1'b0; req_stall = 1'b0;
    tick();
    check("start_stall_gap_valid", {63'd0, ob_valid}, 64'd0);
    tick();
    check("start_after_stall_valid", {63'd0, ob_valid}, 64'd1);
    check("start_after_stall_flag",  {63'd0, ob_start}, 64'd1);
    req_start = 1'b1;
    tick();
    req_start = 1'b0;
    repeat (5) tick();

    // Back to internal mode, then a reset in the middle of the stream.
    cfg_ext = 1'b0;
    repeat (50) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (40) tick();

    check("nogbx_start_total", 64'(u1_start_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
